// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: one-driver-at-a-time register bus transfer sequencer (A/X/Y/S/EXT -> A/X/Y/S); define XFER_FLAGS_EN for N/Z flag outputs
module reg_bus_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_SRC,
  input  logic [1:0] CMD_DST,
  input  logic [7:0] BUS_VALUE,
  output logic       A_BE,
  output logic       X_BE,
  output logic       Y_BE,
  output logic       S_BE,
  output logic       EXT_BE,
  output logic       A_LOAD,
  output logic       X_LOAD,
  output logic       Y_LOAD,
  output logic       S_LOAD,
  output logic       DONE,
  output logic       ERR
`ifdef XFER_FLAGS_EN
  ,
  output logic       FLAG_N,
  output logic       FLAG_Z,
  output logic       FLAG_WE
`endif
);
  typedef enum logic [2:0] {IDLE, DRIVE, LOAD, HOLD, ERROR} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] src_q, src_d;
  logic [1:0] dst_q, dst_d;
  logic illegal, drive;
  logic [4:0] be;
  logic [3:0] ld;
  assign illegal = CMD_SRC > 3'd4 || (!CMD_SRC[2] && CMD_SRC[1:0] == CMD_DST);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    src_d = src_q;
    dst_d = dst_q;
    case (state_q)
      IDLE: if (CMD_VALID) begin
        state_d = illegal ? ERROR : DRIVE;
        cnt_d = illegal ? 4'd0 : 4'(SETTLE_CYCLES - 1);
        src_d = CMD_SRC;
        dst_d = CMD_DST;
      end
      DRIVE: begin
        state_d = cnt_q == 4'd0 ? LOAD : DRIVE;
        cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      LOAD: state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      src_q <= '0;
      dst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      dst_q <= dst_d;
    end
  end
  // Strobes are gated by RST so an interrupted transfer never drives or loads
  assign drive = !RST && (state_q == DRIVE || state_q == LOAD || state_q == HOLD);
  assign be = drive ? 5'(1) << src_q : 5'd0;
  assign ld = (!RST && state_q == LOAD) ? 4'(1) << dst_q : 4'd0;
  assign {EXT_BE, S_BE, Y_BE, X_BE, A_BE} = be;
  assign {S_LOAD, Y_LOAD, X_LOAD, A_LOAD} = ld;
  assign CMD_READY = state_q == IDLE;
  assign DONE = state_q == HOLD;
  assign ERR = state_q == ERROR;
`ifdef XFER_FLAGS_EN
  logic flag_n_q, flag_z_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (state_q == LOAD && dst_q != 2'd3) begin
      flag_n_q <= BUS_VALUE[7];
      flag_z_q <= BUS_VALUE == 8'h00;
    end
  end
  assign FLAG_N = flag_n_q;
  assign FLAG_Z = flag_z_q;
  assign FLAG_WE = state_q == HOLD && dst_q != 2'd3;
`else
  logic unused_bus;
  assign unused_bus = ^BUS_VALUE;
`endif
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert ($countones(be) <= 1) else $error("multiple bus drivers %b", be);
      assert ($countones(ld) <= 1) else $error("multiple loads %b", ld);
      assert (ld == 4'd0 || be[src_q]) else $error("load without source drive");
      assert (!(state_q == IDLE || state_q == ERROR) || (be == 5'd0 && ld == 4'd0))
        else $error("strobe active while idle");
    end
  end
endmodule

// File: tb/tb_reg_bus_sequencer.sv
// tb_reg_bus_sequencer: checks two sequencers (settle 1 and 3) cycle by cycle against a timeline model
module tb_reg_bus_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst   [2];
  logic       valid [2];
  logic [2:0] src   [2];
  logic [1:0] dst   [2];
  logic [7:0] bus   [2];
  logic       ready [2];
  logic [4:0] be    [2];
  logic [3:0] ld    [2];
  logic       done  [2];
  logic       err   [2];
  logic [2:0] fl    [2];
  bit fn [2];
  bit fz [2];
  int n_assert = 0;
  int n_fail = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic a_be, x_be, y_be, s_be, e_be, a_ld, x_ld, y_ld, s_ld;
`ifdef XFER_FLAGS_EN
    logic f_n, f_z, f_we;
    assign fl[g] = {f_we, f_n, f_z};
`else
    assign fl[g] = 3'b000;
`endif
    reg_bus_sequencer #(.SETTLE_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .CLK(clk), .RST(rst[g]), .CMD_VALID(valid[g]), .CMD_READY(ready[g]),
      .CMD_SRC(src[g]), .CMD_DST(dst[g]), .BUS_VALUE(bus[g]),
      .A_BE(a_be), .X_BE(x_be), .Y_BE(y_be), .S_BE(s_be), .EXT_BE(e_be),
      .A_LOAD(a_ld), .X_LOAD(x_ld), .Y_LOAD(y_ld), .S_LOAD(s_ld),
      .DONE(done[g]), .ERR(err[g])
`ifdef XFER_FLAGS_EN
      , .FLAG_N(f_n), .FLAG_Z(f_z), .FLAG_WE(f_we)
`endif
    );
    assign be[g] = {e_be, s_be, y_be, x_be, a_be};
    assign ld[g] = {s_ld, y_ld, x_ld, a_ld};
  end
  function automatic logic [14:0] obs(int d);
    return {ready[d], be[d], ld[d], done[d], err[d], fl[d]};
  endfunction
  // Expected outputs in cycle k after acceptance (k=0 or illegal/past end means idle)
  function automatic logic [14:0] exp_vec(int s, int sr, int ds, bit legal, int k, bit n, bit z);
    logic [4:0] b;
    logic [3:0] l;
    bit r, dn, e, we;
    b = '0; l = '0; r = 1'b0; dn = 1'b0; e = 1'b0; we = 1'b0;
    if (!legal) begin
      e = k == 1;
      r = k != 1;
    end else begin
      if (k >= 1 && k <= s + 2) b = 5'(1) << sr;
      if (k == s + 1) l = 4'(1) << ds;
      dn = k == s + 2;
      we = dn && ds != 3;
      r = k >= s + 3;
    end
`ifdef XFER_FLAGS_EN
    return {r, b, l, dn, e, we, n, z};
`else
    return {r, b, l, dn, e, 3'b000};
`endif
  endfunction
  task automatic check(int d, logic [14:0] e, string tag);
    n_assert++;
    assert (obs(d) === e) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs(d), e);
    end
  endtask
  // Issues one command from a negedge in IDLE; returns at the negedge of the first ready cycle
  task automatic cmd(int d, int sr, int ds, logic [7:0] bv);
    int s = d == 0 ? 1 : 3;
    bit legal = sr <= 4 && !(sr <= 3 && sr == ds);
    int last = legal ? s + 3 : 2;
    valid[d] = 1'b1; src[d] = 3'(sr); dst[d] = 2'(ds); bus[d] = 8'($urandom);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      valid[d] = k < last ? 1'($urandom) : 1'b0;
      src[d] = 3'($urandom);
      dst[d] = 2'($urandom);
      bus[d] = k == s + 1 ? bv : 8'($urandom);
      if (legal && k == s + 2 && ds != 3) begin
        fn[d] = bv[7];
        fz[d] = bv == 8'h00;
      end
      @(negedge clk);
      check(d, exp_vec(s, sr, ds, legal, k, fn[d], fz[d]), $sformatf("xfer_%0d_to_%0d_k%0d", sr, ds, k));
    end
  endtask
  task automatic idle(int d, int n);
    repeat (n) begin
      @(posedge clk); #1;
      @(negedge clk);
      check(d, exp_vec(0, 0, 0, 1'b0, 0, fn[d], fz[d]), "idle");
    end
  endtask
  task automatic rst_mid(int d);
    valid[d] = 1'b1; src[d] = 3'd0; dst[d] = 2'd2; bus[d] = 8'h3C;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      valid[d] = 1'b0;
      @(negedge clk);
      check(d, exp_vec(3, 0, 2, 1'b1, k, fn[d], fz[d]), $sformatf("rst_mid_drive_k%0d", k));
    end
    @(posedge clk); #1;
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    fn[d] = 1'b0;
    fz[d] = 1'b0;
    @(negedge clk);
    check(d, exp_vec(0, 0, 0, 1'b0, 0, fn[d], fz[d]), "rst_mid_after");
    idle(d, 2);
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; src[d] = '0; dst[d] = '0; bus[d] = '0;
      fn[d] = 1'b0; fz[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check(0, exp_vec(0, 0, 0, 1'b0, 0, 1'b0, 1'b0), "reset");
    check(1, exp_vec(0, 0, 0, 1'b0, 0, 1'b0, 1'b0), "reset");
    cmd(0, 1, 0, 8'h80);
    cmd(1, 4, 1, 8'hAA);
    cmd(1, 1, 2, 8'h55);
    cmd(0, 5, 0, 8'h12);
    cmd(0, 2, 2, 8'h34);
    cmd(0, 1, 3, 8'h00);
    idle(0, 1);
    rst_mid(1);
    for (int i = 0; i < 60; i++) begin
      int d = int'($urandom_range(0, 1));
      cmd(d, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 8'($urandom));
      idle(d, int'($urandom_range(0, 2)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
